cp0_exception_unit: RTL and testbench

Coprocessor-0 register file and exception/interrupt arbiter for the five-stage MIPS pipeline. It evaluates exceptions and pending interrupts at the MEM stage and holds Status, Cause, EPC, BadVAddr, Count and Compare. It drives the exception-answer, cause and EPC/ERET signals consumed by the next-PC selector. It is the producer of the answer/cause/EPC handshake that the next-PC logic only consumes.

---
 rtl/cp0_exception_unit_if.sv | 39 +++
 rtl/cp0_exception_unit.sv | 172 +++++++++++++++++
 tb/tb_cp0_exception_unit.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/cp0_exception_unit_if.sv
// MEM-stage <-> CP0 handshake: exception/ERET/MTC0 requests in, answer/cause/EPC out.
interface cp0_exception_unit_if;
    logic        i_MEM_valid;
    logic [31:0] i_MEM_pc;
    logic        i_MEM_is_delay_slot;
    logic        i_MEM_exception_valid;
    logic [4:0]  i_MEM_exception_cause;
    logic [31:0] i_MEM_bad_vaddr;
    logic        i_MEM_is_eret;
    logic        i_MEM_cp0_we;
    logic [4:0]  i_MEM_cp0_waddr;
    logic [31:0] i_MEM_cp0_wdata;
    logic [4:0]  i_cp0_raddr;
    logic [4:0]  i_ext_int;
    logic [31:0] o_cp0_rdata;
    logic        o_answer_exc;
    logic [4:0]  o_MEM_exception_cause;
    logic        o_MEM_is_eret;
    logic [31:0] o_MEM_epc_value;
    logic        o_flush;

    // Pipeline side: presents the MEM instruction, consumes the redirect decision.
    modport master (
        output i_MEM_valid, i_MEM_pc, i_MEM_is_delay_slot, i_MEM_exception_valid,
               i_MEM_exception_cause, i_MEM_bad_vaddr, i_MEM_is_eret, i_MEM_cp0_we,
               i_MEM_cp0_waddr, i_MEM_cp0_wdata, i_cp0_raddr, i_ext_int,
        input  o_cp0_rdata, o_answer_exc, o_MEM_exception_cause, o_MEM_is_eret,
               o_MEM_epc_value, o_flush
    );

    // CP0 side: produces the answer/cause/EPC handshake.
    modport slave (
        input  i_MEM_valid, i_MEM_pc, i_MEM_is_delay_slot, i_MEM_exception_valid,
               i_MEM_exception_cause, i_MEM_bad_vaddr, i_MEM_is_eret, i_MEM_cp0_we,
               i_MEM_cp0_waddr, i_MEM_cp0_wdata, i_cp0_raddr, i_ext_int,
        output o_cp0_rdata, o_answer_exc, o_MEM_exception_cause, o_MEM_is_eret,
               o_MEM_epc_value, o_flush
    );
endinterface

// File: rtl/cp0_exception_unit.sv
// CP0 register file (Status/Cause/EPC/BadVAddr/Count/Compare) and MEM-stage
// exception/interrupt arbiter driving the next-PC redirect.
module cp0_exception_unit #(
    parameter int unsigned COUNT_DIV = 2
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    cp0_exception_unit_if.slave  bus
);
    typedef enum logic [4:0] {
        EXC_INT  = 5'd0,
        EXC_ADEL = 5'd4,
        EXC_ADES = 5'd5,
        EXC_SYS  = 5'd8,
        EXC_BP   = 5'd9,
        EXC_RI   = 5'd10,
        EXC_OV   = 5'd12,
        EXC_TRAP = 5'd13
    } exc_code_e;

    typedef enum logic [4:0] {
        REG_BADVADDR = 5'd8,
        REG_COUNT    = 5'd9,
        REG_COMPARE  = 5'd11,
        REG_STATUS   = 5'd12,
        REG_CAUSE    = 5'd13,
        REG_EPC      = 5'd14
    } cp0_reg_e;

    localparam int unsigned PW = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;

    logic          status_ie_q,  status_ie_d;
    logic          status_exl_q, status_exl_d;
    logic [7:0]    status_im_q,  status_im_d;
    logic          cause_bd_q,   cause_bd_d;
    logic [1:0]    ip_sw_q,      ip_sw_d;
    logic [4:0]    ext_int_q,    ext_int_d;
    logic          ip7_q,        ip7_d;
    logic [4:0]    exc_code_q,   exc_code_d;
    logic [31:0]   epc_q,        epc_d;
    logic [31:0]   badvaddr_q,   badvaddr_d;
    logic [31:0]   count_q,      count_d;
    logic [31:0]   compare_q,    compare_d;
    logic [PW-1:0] presc_q,      presc_d;

    logic [7:0]    ip;
    logic          int_pending;
    logic          answer;
    logic          eret_ok;
    logic [4:0]    taken_cause;

    // Same-cycle redirect decision; interrupts take priority over synchronous exceptions.
    always_comb begin
        ip          = {ip7_q, ext_int_q, ip_sw_q};
        int_pending = status_ie_q & ~status_exl_q & (|(ip & status_im_q));
        answer      = ~status_exl_q & bus.i_MEM_valid & (int_pending | bus.i_MEM_exception_valid);
        eret_ok     = bus.i_MEM_is_eret & bus.i_MEM_valid & ~answer;
        taken_cause = int_pending ? EXC_INT : bus.i_MEM_exception_cause;
    end

    assign bus.o_answer_exc          = answer;
    assign bus.o_MEM_exception_cause = taken_cause;
    assign bus.o_MEM_is_eret         = eret_ok;
    assign bus.o_MEM_epc_value       = epc_q;
    assign bus.o_flush               = answer | eret_ok;

    // MFC0 read mux; state only, a same-cycle MTC0 is not forwarded.
    always_comb begin
        bus.o_cp0_rdata = '0;
        case (bus.i_cp0_raddr)
            REG_BADVADDR: bus.o_cp0_rdata = badvaddr_q;
            REG_COUNT:    bus.o_cp0_rdata = count_q;
            REG_COMPARE:  bus.o_cp0_rdata = compare_q;
            REG_STATUS:   bus.o_cp0_rdata = {16'h0, status_im_q, 6'h0, status_exl_q, status_ie_q};
            REG_CAUSE:    bus.o_cp0_rdata = {cause_bd_q, 15'h0, ip, 1'b0, exc_code_q, 2'b00};
            REG_EPC:      bus.o_cp0_rdata = epc_q;
            default:      bus.o_cp0_rdata = '0;
        endcase
    end

    // Next-state: timer, then MTC0, then exception entry, then ERET.
    // Exception entry is applied after MTC0 so it overrides any field the write touched;
    // MTC0 is gated by ~answer anyway, so the order only matters for readability.
    always_comb begin
        status_ie_d  = status_ie_q;
        status_exl_d = status_exl_q;
        status_im_d  = status_im_q;
        cause_bd_d   = cause_bd_q;
        ip_sw_d      = ip_sw_q;
        ext_int_d    = bus.i_ext_int;
        ip7_d        = ip7_q | (count_q == compare_q);
        exc_code_d   = exc_code_q;
        epc_d        = epc_q;
        badvaddr_d   = badvaddr_q;
        compare_d    = compare_q;
        count_d      = count_q;
        presc_d      = presc_q + 1'b1;
        if (presc_q == PW'(COUNT_DIV - 1)) begin
            presc_d = '0;
            count_d = count_q + 32'd1;
        end

        if (bus.i_MEM_cp0_we && !answer) begin
            case (bus.i_MEM_cp0_waddr)
                REG_COUNT: begin
                    count_d = bus.i_MEM_cp0_wdata;
                    presc_d = '0;
                end
                REG_COMPARE: begin
                    compare_d = bus.i_MEM_cp0_wdata;
                    ip7_d     = 1'b0;
                end
                REG_STATUS: begin
                    status_ie_d  = bus.i_MEM_cp0_wdata[0];
                    status_exl_d = bus.i_MEM_cp0_wdata[1];
                    status_im_d  = bus.i_MEM_cp0_wdata[15:8];
                end
                REG_CAUSE: ip_sw_d = bus.i_MEM_cp0_wdata[9:8];
                REG_EPC:   epc_d   = bus.i_MEM_cp0_wdata;
                default: ;
            endcase
        end

        if (answer) begin
            status_exl_d = 1'b1;
            epc_d        = bus.i_MEM_is_delay_slot ? (bus.i_MEM_pc - 32'd4) : bus.i_MEM_pc;
            cause_bd_d   = bus.i_MEM_is_delay_slot;
            exc_code_d   = taken_cause;
            if (!int_pending && (bus.i_MEM_exception_cause == EXC_ADEL ||
                                 bus.i_MEM_exception_cause == EXC_ADES)) begin
                badvaddr_d = bus.i_MEM_bad_vaddr;
            end
        end

        if (eret_ok) begin
            status_exl_d = 1'b0;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            status_ie_q  <= 1'b0;
            status_exl_q <= 1'b0;
            status_im_q  <= '0;
            cause_bd_q   <= 1'b0;
            ip_sw_q      <= '0;
            ext_int_q    <= '0;
            ip7_q        <= 1'b0;
            exc_code_q   <= '0;
            epc_q        <= '0;
            badvaddr_q   <= '0;
            count_q      <= '0;
            compare_q    <= '0;
            presc_q      <= '0;
        end else begin
            status_ie_q  <= status_ie_d;
            status_exl_q <= status_exl_d;
            status_im_q  <= status_im_d;
            cause_bd_q   <= cause_bd_d;
            ip_sw_q      <= ip_sw_d;
            ext_int_q    <= ext_int_d;
            ip7_q        <= ip7_d;
            exc_code_q   <= exc_code_d;
            epc_q        <= epc_d;
            badvaddr_q   <= badvaddr_d;
            count_q      <= count_d;
            compare_q    <= compare_d;
            presc_q      <= presc_d;
        end
    end
endmodule

// File: tb/tb_cp0_exception_unit.sv
// Directed table-driven bench for cp0_exception_unit plus timer/reset sequences.
module tb_cp0_exception_unit;
    logic clk;
    logic rst;
    int   errors;
    int   checks;

    cp0_exception_unit_if bus();

    cp0_exception_unit #(.COUNT_DIV(2)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    typedef struct {
        logic        valid;
        logic [31:0] pc;
        logic        ds;
        logic        exc_v;
        logic [4:0]  exc_c;
        logic [31:0] bad;
        logic        eret;
        logic        we;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic [4:0]  raddr;
        logic [4:0]  ext;
        logic        e_ans;
        logic [4:0]  e_cause;
        logic        e_eret;
        logic [31:0] e_epc;
        logic        e_flush;
        logic [31:0] e_rdata;
    } vec_t;

    vec_t tbl[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic vec_t mk(
        input logic valid, input logic [31:0] pc, input logic ds, input logic exc_v,
        input logic [4:0] exc_c, input logic [31:0] bad, input logic eret, input logic we,
        input logic [4:0] waddr, input logic [31:0] wdata, input logic [4:0] raddr,
        input logic [4:0] ext, input logic e_ans, input logic [4:0] e_cause,
        input logic e_eret, input logic [31:0] e_epc, input logic e_flush,
        input logic [31:0] e_rdata);
        vec_t v;
        v.valid = valid; v.pc = pc; v.ds = ds; v.exc_v = exc_v; v.exc_c = exc_c;
        v.bad = bad; v.eret = eret; v.we = we; v.waddr = waddr; v.wdata = wdata;
        v.raddr = raddr; v.ext = ext; v.e_ans = e_ans; v.e_cause = e_cause;
        v.e_eret = e_eret; v.e_epc = e_epc; v.e_flush = e_flush; v.e_rdata = e_rdata;
        return v;
    endfunction

    function automatic vec_t idle_vec();
        return mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endfunction

    task automatic apply(input vec_t v);
        bus.i_MEM_valid           = v.valid;
        bus.i_MEM_pc              = v.pc;
        bus.i_MEM_is_delay_slot   = v.ds;
        bus.i_MEM_exception_valid = v.exc_v;
        bus.i_MEM_exception_cause = v.exc_c;
        bus.i_MEM_bad_vaddr       = v.bad;
        bus.i_MEM_is_eret         = v.eret;
        bus.i_MEM_cp0_we          = v.we;
        bus.i_MEM_cp0_waddr       = v.waddr;
        bus.i_MEM_cp0_wdata       = v.wdata;
        bus.i_cp0_raddr           = v.raddr;
        bus.i_ext_int             = v.ext;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        apply(idle_vec());
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        vec_t v;
        errors = 0;
        checks = 0;

        // valid pc ds excv excc bad eret we waddr wdata raddr ext | ans cause eret epc flush rdata
        tbl.push_back(mk(0, 0,      0,0,0, 0,      0,1,11,32'hFFFF_FFF0,12,0, 0,0,0,0,       0,0));
        tbl.push_back(mk(0, 0,      0,0,0, 0,      0,1,12,32'h401,      11,0, 0,0,0,0,       0,32'hFFFF_FFF0));
        tbl.push_back(mk(1, 32'h100,0,0,0, 0,      0,0,0, 0,            12,1, 0,0,0,0,       0,32'h401));
        tbl.push_back(mk(1, 32'h100,0,0,0, 0,      0,0,0, 0,            13,1, 1,0,0,0,       1,32'h400));
        tbl.push_back(mk(0, 0,      0,0,0, 0,      0,0,0, 0,            12,0, 0,0,0,32'h100, 0,32'h403));
        tbl.push_back(mk(0, 0,      0,0,0, 0,      0,0,0, 0,            14,0, 0,0,0,32'h100, 0,32'h100));
        tbl.push_back(mk(1, 32'h104,0,0,0, 0,      1,0,0, 0,            12,0, 0,0,1,32'h100, 1,32'h403));
        tbl.push_back(mk(0, 0,      0,0,0, 0,      0,0,0, 0,            12,0, 0,0,0,32'h100, 0,32'h401));
        tbl.push_back(mk(1, 32'h204,1,1,12,0,      0,0,0, 0,            13,0, 1,12,0,32'h100,1,0));
        tbl.push_back(mk(0, 0,      0,0,0, 0,      0,0,0, 0,            13,0, 0,0,0,32'h200, 0,32'h8000_0030));
        tbl.push_back(mk(1, 32'h208,0,0,0, 0,      1,0,0, 0,            14,0, 0,0,1,32'h200, 1,32'h200));
        tbl.push_back(mk(1, 32'h300,0,1,4, 32'h1003,0,1,14,32'hDEAD_BEEF,8, 0, 1,4,0,32'h200, 1,0));
        tbl.push_back(mk(0, 0,      0,0,0, 0,      0,0,0, 0,            8, 0, 0,0,0,32'h300, 0,32'h1003));
        tbl.push_back(mk(1, 32'h400,0,1,8, 0,      0,0,0, 0,            13,0, 0,8,0,32'h300, 0,32'h10));
        tbl.push_back(mk(1, 32'h404,0,0,0, 0,      1,0,0, 0,            12,0, 0,0,1,32'h300, 1,32'h403));
        tbl.push_back(mk(0, 0,      0,0,0, 0,      0,0,0, 0,            12,1, 0,0,0,32'h300, 0,32'h401));
        tbl.push_back(mk(0, 0,      0,0,0, 0,      0,0,0, 0,            13,1, 0,0,0,32'h300, 0,32'h410));
        tbl.push_back(mk(1, 32'h500,0,1,10,0,      0,0,0, 0,            13,1, 1,0,0,32'h300, 1,32'h410));
        tbl.push_back(mk(0, 0,      0,0,0, 0,      0,0,0, 0,            13,0, 0,0,0,32'h500, 0,32'h400));
        tbl.push_back(mk(1, 32'h504,0,0,0, 0,      1,0,0, 0,            12,0, 0,0,1,32'h500, 1,32'h403));
        tbl.push_back(mk(1, 32'h508,0,0,0, 0,      1,0,0, 0,            12,0, 0,0,1,32'h500, 1,32'h401));
        tbl.push_back(mk(1, 32'h50C,0,0,0, 0,      0,1,13,32'hFFFF_FFFF,13,0, 0,0,0,32'h500, 0,0));
        tbl.push_back(mk(0, 0,      0,0,0, 0,      0,0,0, 0,            13,0, 0,0,0,32'h500, 0,32'h300));
        tbl.push_back(mk(1, 32'h510,0,0,0, 0,      0,1,12,32'h101,      13,0, 0,0,0,32'h500, 0,32'h300));
        tbl.push_back(mk(1, 32'h600,0,0,0, 0,      0,0,0, 0,            12,0, 1,0,0,32'h500, 1,32'h101));
        tbl.push_back(mk(1, 32'h604,0,0,0, 0,      0,1,13,0,            14,0, 0,0,0,32'h600, 0,32'h600));
        tbl.push_back(mk(1, 32'h608,0,0,0, 0,      0,1,12,0,            13,0, 0,0,0,32'h600, 0,0));
        tbl.push_back(mk(0, 0,      0,0,0, 0,      0,0,0, 0,            12,0, 0,0,0,32'h600, 0,0));
        tbl.push_back(mk(0, 0,      0,0,0, 0,      0,0,0, 0,            31,0, 0,0,0,32'h600, 0,0));

        rst = 1'b1;
        apply(idle_vec());
        @(negedge clk);
        rst = 1'b0;

        foreach (tbl[i]) begin
            apply(tbl[i]);
            #2;
            chk($sformatf("row%0d answer", i), 32'(bus.o_answer_exc), 32'(tbl[i].e_ans));
            chk($sformatf("row%0d cause", i), 32'(bus.o_MEM_exception_cause), 32'(tbl[i].e_cause));
            chk($sformatf("row%0d eret", i), 32'(bus.o_MEM_is_eret), 32'(tbl[i].e_eret));
            chk($sformatf("row%0d epc", i), bus.o_MEM_epc_value, tbl[i].e_epc);
            chk($sformatf("row%0d flush", i), 32'(bus.o_flush), 32'(tbl[i].e_flush));
            chk($sformatf("row%0d rdata", i), bus.o_cp0_rdata, tbl[i].e_rdata);
            @(negedge clk);
        end

        // Reset while EXL=1 clears EXL and EPC.
        v = idle_vec();
        v.valid = 1; v.pc = 32'h800; v.exc_v = 1; v.exc_c = 13;
        apply(v);
        #2;
        chk("mid answer", 32'(bus.o_answer_exc), 32'd1);
        chk("mid cause", 32'(bus.o_MEM_exception_cause), 32'd13);
        @(negedge clk);
        v = idle_vec();
        v.raddr = 12;
        apply(v);
        rst = 1'b1;
        #2;
        chk("mid pre-reset epc", bus.o_MEM_epc_value, 32'h800);
        chk("mid pre-reset status", bus.o_cp0_rdata, 32'h2);
        @(negedge clk);
        rst = 1'b0;
        #2;
        chk("post-reset epc", bus.o_MEM_epc_value, 32'h0);
        chk("post-reset status", bus.o_cp0_rdata, 32'h0);
        chk("post-reset flush", 32'(bus.o_flush), 32'd0);
        @(negedge clk);

        // Timer: Compare=5 with COUNT_DIV=2 matches in cycles 10-11, IP7 visible from cycle 11.
        do_reset();
        for (int k = 0; k <= 22; k++) begin
            v = idle_vec();
            case (k)
                0:       begin v.we = 1; v.waddr = 11; v.wdata = 32'd5; end
                1:       begin v.we = 1; v.waddr = 12; v.wdata = 32'h8001; end
                13:      begin v.valid = 1; v.pc = 32'h700; end
                14:      begin v.we = 1; v.waddr = 11; v.wdata = 32'd9; v.raddr = 9; end
                18, 19:  begin v.we = 1; v.waddr = 11; v.wdata = 32'd9; v.raddr = 13; end
                default: v.raddr = 13;
            endcase
            apply(v);
            #2;
            if (k >= 2 && k <= 12)
                chk($sformatf("timer ip7 k%0d", k), 32'(bus.o_cp0_rdata[15]), 32'(k >= 11));
            if (k == 13) begin
                chk("timer answer", 32'(bus.o_answer_exc), 32'd1);
                chk("timer cause", 32'(bus.o_MEM_exception_cause), 32'd0);
            end
            if (k == 14)
                chk("timer count", bus.o_cp0_rdata, 32'd7);
            if (k == 15 || k >= 20)
                chk($sformatf("timer ip7 clear k%0d", k), 32'(bus.o_cp0_rdata[15]), 32'd0);
            @(negedge clk);
        end

        // Count wrap from 0xFFFF_FFFF.
        do_reset();
        for (int k = 0; k <= 3; k++) begin
            v = idle_vec();
            if (k == 0) begin
                v.we = 1; v.waddr = 9; v.wdata = 32'hFFFF_FFFF;
            end else begin
                v.raddr = 9;
            end
            apply(v);
            #2;
            if (k == 1 || k == 2)
                chk($sformatf("count hold k%0d", k), bus.o_cp0_rdata, 32'hFFFF_FFFF);
            if (k == 3)
                chk("count wrap", bus.o_cp0_rdata, 32'h0);
            @(negedge clk);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
